// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared state, instruction-class and select encodings for the multicycle controller.
package mc_ctrl_pkg;
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        C_ADDU, C_SUBU, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_JAL, C_JR
    } iclass_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_JR    = 6'h08;

    localparam logic [3:0] EXT_ZERO = 4'd0;
    localparam logic [3:0] EXT_SIGN = 4'd1;
    localparam logic [3:0] EXT_HIGH = 4'd2;
    localparam logic [1:0] ALU_ADD  = 2'd0;
    localparam logic [1:0] ALU_SUB  = 2'd1;
    localparam logic [1:0] ALU_OR   = 2'd2;
    localparam logic       ALUB_RD2 = 1'b0;
    localparam logic       ALUB_IMM = 1'b1;
    localparam logic [1:0] A3_RT    = 2'd0;
    localparam logic [1:0] A3_RD    = 2'd1;
    localparam logic [1:0] A3_RA    = 2'd2;
    localparam logic [1:0] WD_ALU   = 2'd0;
    localparam logic [1:0] WD_DM    = 2'd1;
    localparam logic [1:0] WD_PC    = 2'd2;
    localparam logic [1:0] NPC_PC4  = 2'd0;
    localparam logic [1:0] NPC_BR   = 2'd1;
    localparam logic [1:0] NPC_J    = 2'd2;
    localparam logic [1:0] NPC_RS   = 2'd3;
endpackage

// File: rtl/mc_decode.sv
// mc_decode: classifies the instruction register into a supported class or flags it illegal.
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [31:0] instr_i,
    output iclass_t     cls_o,
    output logic        illegal_o
);
    logic [5:0] op;
    logic [5:0] fn;
    assign op = instr_i[31:26];
    assign fn = instr_i[5:0];

    always_comb begin
        cls_o     = C_ADDU;
        illegal_o = 1'b0;
        case (op)
            // an all-zero word is the canonical nop and executes as addu
            OP_RTYPE: begin
                if (instr_i == 32'd0 || fn == FN_ADDU) cls_o = C_ADDU;
                else if (fn == FN_SUBU) cls_o = C_SUBU;
                else if (fn == FN_JR) cls_o = C_JR;
                else illegal_o = 1'b1;
            end
            OP_ORI:  cls_o = C_ORI;
            OP_LUI:  cls_o = C_LUI;
            OP_LW:   cls_o = C_LW;
            OP_SW:   cls_o = C_SW;
            OP_BEQ:  cls_o = C_BEQ;
            OP_JAL:  cls_o = C_JAL;
            default: illegal_o = 1'b1;
        endcase
    end
endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: Moore multicycle controller (FETCH/DECODE/EXEC/MEM/WB) with a retired-instruction counter.
module mc_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic [3:0]  ext_op,
    output logic [1:0]  alu_op,
    output logic        alub_sel,
    output logic [1:0]  a3_sel,
    output logic [1:0]  wd_sel,
    output logic [1:0]  npc_sel,
    output logic        pc_we,
    output logic        ir_we,
    output logic        rf_we,
    output logic        dm_we,
    output logic        mem_req,
    output logic        illegal,
    output logic [2:0]  state,
    output logic [31:0] retired
);
    state_t      state_q, state_d;
    logic [31:0] retired_q, retired_d;
    iclass_t     cls;
    logic        dec_ill;
    logic        retire;

    mc_decode u_decode (
        .instr_i   (instr),
        .cls_o     (cls),
        .illegal_o (dec_ill)
    );

    always_comb begin
        state_d  = state_q;
        ext_op   = EXT_ZERO;
        alu_op   = ALU_ADD;
        alub_sel = ALUB_RD2;
        a3_sel   = A3_RT;
        wd_sel   = WD_ALU;
        npc_sel  = NPC_PC4;
        pc_we    = 1'b0;
        ir_we    = 1'b0;
        rf_we    = 1'b0;
        dm_we    = 1'b0;
        mem_req  = 1'b0;
        illegal  = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
                pc_we   = mem_ready;
                state_d = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                illegal = dec_ill;
                state_d = dec_ill ? S_FETCH : S_EXEC;
            end
            S_EXEC: begin
                case (cls)
                    C_ADDU: state_d = S_WB;
                    C_SUBU: begin alu_op = ALU_SUB; state_d = S_WB; end
                    C_ORI:  begin alu_op = ALU_OR; alub_sel = ALUB_IMM; state_d = S_WB; end
                    C_LUI:  begin ext_op = EXT_HIGH; alu_op = ALU_OR; alub_sel = ALUB_IMM; state_d = S_WB; end
                    C_LW, C_SW: begin ext_op = EXT_SIGN; alub_sel = ALUB_IMM; state_d = S_MEM; end
                    C_BEQ:  begin ext_op = EXT_SIGN; alu_op = ALU_SUB; npc_sel = NPC_BR; pc_we = zero; state_d = S_FETCH; end
                    C_JAL:  begin pc_we = 1'b1; npc_sel = NPC_J; rf_we = 1'b1; a3_sel = A3_RA; wd_sel = WD_PC; state_d = S_FETCH; end
                    C_JR:   begin pc_we = 1'b1; npc_sel = NPC_RS; state_d = S_FETCH; end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                mem_req  = 1'b1;
                ext_op   = EXT_SIGN;
                alub_sel = ALUB_IMM;
                dm_we    = mem_ready && cls == C_SW;
                if (mem_ready) state_d = (cls == C_LW) ? S_WB : S_FETCH;
            end
            S_WB: begin
                rf_we   = 1'b1;
                a3_sel  = (cls == C_ADDU || cls == C_SUBU) ? A3_RD : A3_RT;
                wd_sel  = (cls == C_LW) ? WD_DM : WD_ALU;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
        // outputs are combinational, so reset must mask them explicitly
        if (!reset) {ext_op, alu_op, alub_sel, a3_sel, wd_sel, npc_sel, pc_we, ir_we, rf_we, dm_we, mem_req, illegal} = '0;
    end

    assign retire    = (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) && state_d == S_FETCH;
    assign retired_d = retired_q + {31'd0, retire};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            retired_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    assign state   = state_q;
    assign retired = retired_q;
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: table-driven cycle-by-cycle check of the multicycle controller.
module tb_mc_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instr = 32'd0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic [3:0]  ext_op;
    logic [1:0]  alu_op, a3_sel, wd_sel, npc_sel;
    logic        alub_sel, pc_we, ir_we, rf_we, dm_we, mem_req, illegal;
    logic [2:0]  state;
    logic [31:0] retired;

    always #5 clk = ~clk;

    mc_ctrl dut (
        .clk(clk), .reset(reset), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .ext_op(ext_op), .alu_op(alu_op), .alub_sel(alub_sel), .a3_sel(a3_sel),
        .wd_sel(wd_sel), .npc_sel(npc_sel), .pc_we(pc_we), .ir_we(ir_we), .rf_we(rf_we),
        .dm_we(dm_we), .mem_req(mem_req), .illegal(illegal), .state(state), .retired(retired)
    );

    typedef struct {
        logic        rn;
        logic [31:0] in;
        logic        z;
        logic        rdy;
        logic [2:0]  st;
        logic [18:0] ctl;
        logic [31:0] ret;
    } vec_t;

    localparam logic [31:0] ORI  = 32'h34221234;
    localparam logic [31:0] LW   = 32'h8c220004;
    localparam logic [31:0] SW   = 32'hac220004;
    localparam logic [31:0] BEQ  = 32'h10220003;
    localparam logic [31:0] LUI  = 32'h3c011234;
    localparam logic [31:0] JAL  = 32'h0c000010;
    localparam logic [31:0] JR   = 32'h03e00008;
    localparam logic [31:0] ADDU = 32'h00221821;
    localparam logic [31:0] SUBU = 32'h00221823;
    localparam logic [31:0] ILL  = 32'hfc000000;
    localparam logic [31:0] SLT  = 32'h0000002a;
    localparam logic [18:0] NONE = 19'd0;

    vec_t        vq[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] er = 32'd0;

    // packs expected outputs in the same order the bench reads them back
    function automatic logic [18:0] cw(int ext = 0, int alu = 0, int alub = 0, int a3 = 0, int wd = 0,
                                       int npc = 0, int pc = 0, int ir = 0, int rf = 0, int dm = 0,
                                       int mr = 0, int ill = 0);
        return {ext[3:0], alu[1:0], alub[0], a3[1:0], wd[1:0], npc[1:0], pc[0], ir[0], rf[0], dm[0], mr[0], ill[0]};
    endfunction

    function automatic void add(logic rn, logic [31:0] in, logic z, logic rdy, logic [2:0] st, logic [18:0] ctl);
        vq.push_back('{rn, in, z, rdy, st, ctl, er});
    endfunction

    function automatic void front(logic [31:0] in, logic ill);
        add(1, in, 0, 1, 0, cw(.pc(1), .ir(1), .mr(1)));
        add(1, in, 0, 0, 1, ill ? cw(.ill(1)) : NONE);
    endfunction

    task automatic apply(input vec_t v, input int i);
        logic [18:0] got;
        @(negedge clk);
        reset = v.rn;
        instr = v.in;
        zero = v.z;
        mem_ready = v.rdy;
        #1;
        got = {ext_op, alu_op, alub_sel, a3_sel, wd_sel, npc_sel, pc_we, ir_we, rf_we, dm_we, mem_req, illegal};
        tests++;
        if ({got, state, retired} !== {v.ctl, v.st, v.ret}) begin
            fails++;
            $display("FAIL vec%0d instr=%h: got ctl=%h state=%0d retired=%h, expected ctl=%h state=%0d retired=%h",
                     i, v.in, got, state, retired, v.ctl, v.st, v.ret);
        end
    endtask

    initial begin
        add(0, 0, 0, 1, 0, NONE);
        add(0, 0, 0, 1, 0, NONE);
        front(ORI, 0);
        add(1, ORI, 0, 1, 2, cw(.alu(2), .alub(1)));
        add(1, ORI, 0, 1, 4, cw(.rf(1)));
        er++;
        add(1, LW, 0, 0, 0, cw(.mr(1)));
        front(LW, 0);
        add(1, LW, 0, 1, 2, cw(.ext(1), .alub(1)));
        repeat (3) add(1, LW, 0, 0, 3, cw(.ext(1), .alub(1), .mr(1)));
        add(1, LW, 0, 1, 3, cw(.ext(1), .alub(1), .mr(1)));
        add(1, LW, 0, 0, 4, cw(.rf(1), .wd(1)));
        er++;
        front(BEQ, 0);
        add(1, BEQ, 1, 0, 2, cw(.ext(1), .alu(1), .npc(1), .pc(1)));
        er++;
        front(BEQ, 0);
        add(1, BEQ, 0, 1, 2, cw(.ext(1), .alu(1), .npc(1)));
        er++;
        front(LUI, 0);
        add(1, LUI, 0, 1, 2, cw(.ext(2), .alu(2), .alub(1)));
        add(1, LUI, 0, 1, 4, cw(.rf(1)));
        er++;
        front(JAL, 0);
        add(1, JAL, 0, 1, 2, cw(.pc(1), .npc(2), .rf(1), .a3(2), .wd(2)));
        er++;
        front(JR, 0);
        add(1, JR, 0, 1, 2, cw(.pc(1), .npc(3)));
        er++;
        front(ADDU, 0);
        add(1, ADDU, 0, 1, 2, NONE);
        add(1, ADDU, 0, 1, 4, cw(.rf(1), .a3(1)));
        er++;
        front(SUBU, 0);
        add(1, SUBU, 0, 1, 2, cw(.alu(1)));
        add(1, SUBU, 0, 1, 4, cw(.rf(1), .a3(1)));
        er++;
        front(32'd0, 0);
        add(1, 32'd0, 0, 1, 2, NONE);
        add(1, 32'd0, 0, 1, 4, cw(.rf(1), .a3(1)));
        er++;
        front(ILL, 1);
        front(SLT, 1);
        front(SW, 0);
        add(1, SW, 0, 1, 2, cw(.ext(1), .alub(1)));
        add(1, SW, 0, 0, 3, cw(.ext(1), .alub(1), .mr(1)));
        add(1, SW, 0, 1, 3, cw(.ext(1), .alub(1), .mr(1), .dm(1)));
        er++;
        front(SW, 0);
        add(1, SW, 0, 1, 2, cw(.ext(1), .alub(1)));
        add(1, SW, 0, 0, 3, cw(.ext(1), .alub(1), .mr(1)));
        er = 32'd0;
        add(0, SW, 0, 1, 0, NONE);
        add(0, SW, 0, 1, 0, NONE);
        front(ORI, 0);
        add(1, ORI, 0, 1, 2, cw(.alu(2), .alub(1)));
        add(1, ORI, 0, 1, 4, cw(.rf(1)));
        er++;
        add(1, ORI, 0, 0, 0, cw(.mr(1)));
        foreach (vq[i]) apply(vq[i], i);

        // counter wrap: preload all-ones while parked in FETCH, then retire one jr
        vq.delete();
        @(negedge clk);
        force dut.retired_q = 32'hffffffff;
        @(posedge clk);
        @(negedge clk);
        release dut.retired_q;
        er = 32'hffffffff;
        add(1, JR, 0, 0, 0, cw(.mr(1)));
        front(JR, 0);
        add(1, JR, 0, 1, 2, cw(.pc(1), .npc(3)));
        er++;
        add(1, JR, 0, 0, 0, cw(.mr(1)));
        foreach (vq[i]) apply(vq[i], 1000 + i);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state updates on the rising edge.
REQ-002 SHALL have port: reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port: instr  in  32  current instruction-register contents.
REQ-004 SHALL have port: zero  in  1  ALU equality flag, valid in EXEC.
REQ-005 SHALL have port: mem_ready  in  1  memory completes the current mem_req this cycle.
REQ-006 SHALL have outputs (out, width): ext_op 4, alu_op 2, alub_sel 1, a3_sel 2, wd_sel 2, npc_sel 2.
REQ-007 SHALL have outputs (out, width): pc_we 1, ir_we 1, rf_we 1, dm_we 1, mem_req 1, illegal 1, state 3, retired 32.
REQ-008 SHALL use these select encodings:
- ext_op: 0 zero-extend, 1 sign-extend, 2 imm16 into the high half.
- alu_op: 0 ADD, 1 SUB, 2 OR.
- alub_sel: 0 rd2, 1 imm32.
- a3_sel: 0 rt, 1 rd, 2 $31.
- wd_sel: 0 ALU, 1 DM, 2 PC.
- npc_sel: 0 PC+4, 1 branch target, 2 jump target, 3 rs.

Function
REQ-009 SHALL implement a Moore FSM with states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
REQ-010 SHALL drive all control outputs combinationally from state, instr and mem_ready; state and retired are registers.
REQ-011 SHALL, in FETCH, assert mem_req; while mem_ready=0, stay in FETCH with all enables 0.
REQ-012 SHALL, in FETCH with mem_ready=1, pulse ir_we=1 and pc_we=1 (npc_sel=0), then go to DECODE.
REQ-013 SHALL decode addu, subu, ori, lw, sw, beq, lui, jal and jr; nop (instr=0) is addu.
REQ-014 SHALL, in DECODE, go to EXEC for a supported instruction; otherwise pulse illegal=1 for one cycle and return to FETCH with no side effects.
REQ-015 SHALL, in EXEC, drive by class:
- addu/subu: alu_op ADD/SUB, alub_sel=0; then WB.
- ori: ext_op=0, alu_op OR, alub_sel=1; then WB.
- lui: ext_op=2, alu_op OR, alub_sel=1; then WB.
- lw/sw: ext_op=1, alu_op ADD, alub_sel=1; then MEM.
REQ-016 SHALL, for beq in EXEC, drive ext_op=1, alu_op SUB, npc_sel=1, pc_we=zero, then return to FETCH (3 cycles minimum).
REQ-017 SHALL, for jal in EXEC, drive pc_we=1, npc_sel=2, rf_we=1, a3_sel=2, wd_sel=2 (the already-incremented PC), then return to FETCH.
REQ-018 SHALL, for jr in EXEC, drive pc_we=1, npc_sel=3, then return to FETCH.
REQ-019 SHALL, in MEM, hold mem_req=1 and keep the EXEC-state ext_op/alu_op/alub_sel until mem_ready=1.
REQ-020 SHALL, in MEM for sw, assert dm_we=1 only in the mem_ready cycle, then go to FETCH.
REQ-021 SHALL, in MEM for lw, go to WB on mem_ready.
REQ-022 SHALL, in WB, pulse rf_we=1 for one cycle, with a3_sel=1 and wd_sel=0 for addu/subu, a3_sel=0 and wd_sel=0 for ori/lui, and a3_sel=0 and wd_sel=1 for lw, then go to FETCH.
REQ-023 SHALL increment retired by 1 (mod 2^32, wrapping) in each cycle that leaves EXEC, MEM or WB back to FETCH; illegal instructions are not counted.
REQ-024 SHALL drive every unlisted enable to 0 and every unlisted select to 0 in every state.
REQ-025 SHALL make mem_ready irrelevant outside FETCH/MEM, and SHALL never assert rf_we and dm_we in the same cycle.

Reset
REQ-026 SHALL, while reset=0, force state=FETCH and retired=0, and force all outputs to 0 (including mem_req).
REQ-027 SHALL abandon any in-flight instruction when reset is asserted mid-operation, with no write-enable asserted afterwards.
REQ-028 SHALL begin fetch on the first rising edge after reset deasserts.

Structure
REQ-029 SHALL place in shared package mc_ctrl_pkg: the state enum, opcode/funct constants (addu 0x21, subu 0x23, jr 0x08; ori 0x0d, lw 0x23, sw 0x2b, beq 0x04, lui 0x0f, jal 0x03) and all select encodings of REQ-008.
REQ-030 SHALL split instruction classification into one combinational sub-module, mc_decode (instr -> class, illegal).

Verification
REQ-031 SHALL cover: ori with mem_ready=1 constant -> F,D,E,WB; ext_op=0 in EXEC, rf_we for 1 cycle in WB; retired 0->1.
REQ-032 SHALL cover: lw with mem_ready low 3 cycles in MEM -> mem_req held 4 cycles, ext_op=1 stable, then WB with wd_sel=1.
REQ-033 SHALL cover: beq with zero=1 -> pc_we=1, npc_sel=1 in EXEC; with zero=0 -> pc_we=0; 3 cycles each.
REQ-034 SHALL cover: lui 0x3c011234 -> ext_op=2 in EXEC; jal -> a3_sel=2, wd_sel=2, rf_we=1.
REQ-035 SHALL cover: illegal instr 0xfc000000 -> illegal pulse in DECODE, no write-enables, retired unchanged.
REQ-036 SHALL cover: reset pulled low in MEM of sw -> dm_we never asserted, state=0, retired=0; retired=0xffffffff plus one retire -> 0.
